// File: rtl/traffic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | traffic_pkg                                                                |
// | Shared lamp indices, digit slots, segment table and FSM encoding.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package traffic_pkg;

  localparam int NS_RED    = 5;
  localparam int NS_YELLOW = 4;
  localparam int NS_GREEN  = 3;
  localparam int EW_RED    = 2;
  localparam int EW_YELLOW = 1;
  localparam int EW_GREEN  = 0;

  localparam logic [1:0] DIG_EW_UNITS = 2'd0;
  localparam logic [1:0] DIG_EW_TENS  = 2'd1;
  localparam logic [1:0] DIG_NS_UNITS = 2'd2;
  localparam logic [1:0] DIG_NS_TENS  = 2'd3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low {g,f,e,d,c,b,a} patterns for digits 0..9
  localparam logic [6:0] SEG_LUT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    seg_of = (d <= 4'd9) ? SEG_LUT[d] : SEG_DASH;
  endfunction

  // Each direction must show exactly one lamp, and the two greens never together
  function automatic logic lamps_legal(input logic [5:0] l);
    lamps_legal = ($countones(l[NS_RED:NS_GREEN]) == 1) &&
                  ($countones(l[EW_RED:EW_GREEN]) == 1) &&
                  !(l[NS_GREEN] && l[EW_GREEN]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_countdown_display_bin2bcd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bin2bcd_seq                                                                |
// | Single-channel sequential double-dabble converter, one bit per ce tick.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bin2bcd_seq #(
  parameter int BIN_W = 7
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ce_i,
  input  logic             start_i,
  input  logic             shift_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic [7:0]       bcd_o,
  output logic             done_o
);

  localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  logic [BIN_W-1:0] bin_q, bin_d;
  logic [7:0]       bcd_q, bcd_d, adj;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    adj = bcd_q;
    if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
    if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    if (start_i) begin
      bin_d = bin_i;
      bcd_d = '0;
      cnt_d = '0;
    end else if (shift_i) begin
      {bcd_d, bin_d} = {adj, bin_q} << 1;
      cnt_d          = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (ce_i) begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  // Asserted during the tick that performs the final shift
  assign done_o = shift_i && (cnt_q == CW'(BIN_W - 1));
  assign bcd_o  = bcd_q;

endmodule
`default_nettype wire

// File: rtl/traffic_countdown_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | traffic_countdown_display                                                  |
// | Converts NS/EW time-left to BCD and scans a 4-digit active-low display.    |
// | Optional blink of yellow-direction digits: TRAFFIC_DISPLAY_BLINK_EN.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module traffic_countdown_display
  import traffic_pkg::*;
#(
  parameter int _lightsWidth   = 6,
  parameter int _timeLeftWidth = 7,
  parameter int _scanDiv       = 16,
  parameter int _blinkDiv      = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic [_lightsWidth-1:0]   lights,
  input  logic [_timeLeftWidth-1:0] timeLeftNS,
  input  logic [_timeLeftWidth-1:0] timeLeftEW,
  output logic [6:0]                seg,
  output logic [3:0]                an,
  output logic                      dp
);

  localparam int PW = (_scanDiv > 1) ? $clog2(_scanDiv) : 1;

  state_e state_q, state_d;
  logic   start, shift, commit, done_ns, done_ew;

  logic [_timeLeftWidth-1:0] clamp_ns, clamp_ew;
  logic [7:0]                bcd_ns, bcd_ew;

  logic [_lightsWidth-1:0] lcap_q, lcap_d, disp_l_q, disp_l_d;
  logic [7:0]              disp_ns_q, disp_ns_d, disp_ew_q, disp_ew_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [1:0]              digit_q, digit_d;
  logic [6:0]              seg_q, seg_d;
  logic [3:0]              an_q, an_d;
  logic                    dp_q, dp_d;
  logic                    blank_ns, blank_ew;

  assign clamp_ns = (timeLeftNS > _timeLeftWidth'(99)) ? _timeLeftWidth'(99) : timeLeftNS;
  assign clamp_ew = (timeLeftEW > _timeLeftWidth'(99)) ? _timeLeftWidth'(99) : timeLeftEW;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    shift   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE:  state_d = LOAD;
      LOAD: begin
        start   = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        shift = 1'b1;
        if (done_ns && done_ew) state_d = DONE;
      end
      DONE: begin
        commit  = 1'b1;
        state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  bin2bcd_seq #(.BIN_W(_timeLeftWidth)) u_bcd_ns (
    .clk_i   (clk),
    .rst_ni  (rst),
    .ce_i    (ce),
    .start_i (start),
    .shift_i (shift),
    .bin_i   (clamp_ns),
    .bcd_o   (bcd_ns),
    .done_o  (done_ns)
  );

  bin2bcd_seq #(.BIN_W(_timeLeftWidth)) u_bcd_ew (
    .clk_i   (clk),
    .rst_ni  (rst),
    .ce_i    (ce),
    .start_i (start),
    .shift_i (shift),
    .bin_i   (clamp_ew),
    .bcd_o   (bcd_ew),
    .done_o  (done_ew)
  );

  always_comb begin
    lcap_d    = start  ? lights : lcap_q;
    disp_l_d  = commit ? lcap_q : disp_l_q;
    disp_ns_d = commit ? bcd_ns : disp_ns_q;
    disp_ew_d = commit ? bcd_ew : disp_ew_q;
    if (presc_q == PW'(_scanDiv - 1)) begin
      presc_d = '0;
      digit_d = digit_q + 2'd1;
    end else begin
      presc_d = presc_q + 1'b1;
      digit_d = digit_q;
    end
  end

`ifdef TRAFFIC_DISPLAY_BLINK_EN
  localparam int BW = (_blinkDiv > 1) ? $clog2(_blinkDiv) : 1;

  logic [BW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;
  logic          blink_wrap;

  assign blink_wrap = (blink_q == BW'(_blinkDiv - 1));
  assign blink_d    = blink_wrap ? '0 : blink_q + 1'b1;
  assign phase_d    = phase_q ^ blink_wrap;
  assign blank_ns   = disp_l_d[NS_YELLOW] && phase_d;
  assign blank_ew   = disp_l_d[EW_YELLOW] && phase_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_q <= '0;
      phase_q <= 1'b0;
    end else if (ce) begin
      blink_q <= blink_d;
      phase_q <= phase_d;
    end
  end
`else
  assign blank_ns = 1'b0;
  assign blank_ew = 1'b0;
`endif

  // Outputs are decoded from next-state values so seg/an/dp move with the scan index
  always_comb begin
    seg_d = SEG_DASH;
    an_d  = ~(4'b0001 << digit_d);
    dp_d  = 1'b1;
    if (lamps_legal(disp_l_d)) begin
      case (digit_d)
        DIG_EW_UNITS: begin
          seg_d = seg_of(disp_ew_d[3:0]);
          dp_d  = ~disp_l_d[EW_YELLOW];
          if (blank_ew) begin
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
          end
        end
        DIG_EW_TENS: begin
          seg_d = (disp_ew_d[7:4] == 4'd0 || blank_ew) ? SEG_BLANK : seg_of(disp_ew_d[7:4]);
        end
        DIG_NS_UNITS: begin
          seg_d = seg_of(disp_ns_d[3:0]);
          dp_d  = ~disp_l_d[NS_YELLOW];
          if (blank_ns) begin
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
          end
        end
        default: begin
          seg_d = (disp_ns_d[7:4] == 4'd0 || blank_ns) ? SEG_BLANK : seg_of(disp_ns_d[7:4]);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      lcap_q    <= '0;
      disp_l_q  <= '0;
      disp_ns_q <= '0;
      disp_ew_q <= '0;
      presc_q   <= '0;
      digit_q   <= '0;
      seg_q     <= SEG_BLANK;
      an_q      <= 4'hF;
      dp_q      <= 1'b1;
    end else if (ce) begin
      state_q   <= state_d;
      lcap_q    <= lcap_d;
      disp_l_q  <= disp_l_d;
      disp_ns_q <= disp_ns_d;
      disp_ew_q <= disp_ew_d;
      presc_q   <= presc_d;
      digit_q   <= digit_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      dp_q      <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_countdown_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_traffic_countdown_display                                               |
// | Random and directed stimulus against a tick-count reference model.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_traffic_countdown_display;

  localparam int SCAN  = 2;
  localparam int BLINK = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce  = 1'b0;
  logic [5:0] lights = 6'b0;
  logic [6:0] tl_ns  = 7'd0;
  logic [6:0] tl_ew  = 7'd0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int errors = 0;
  int checks = 0;

  traffic_countdown_display #(
    ._scanDiv  (SCAN),
    ._blinkDiv (BLINK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .lights     (lights),
    .timeLeftNS (tl_ns),
    .timeLeftEW (tl_ew),
    .seg        (seg),
    .an         (an),
    .dp         (dp)
  );

  always #5 clk = ~clk;

  // Reference model: everything is a function of the ce-tick count since reset
  int         n;
  int         disp_ns, disp_ew, pend_ns, pend_ew;
  logic [5:0] disp_l, pend_l;

  // Active-high gfedcba patterns; the display uses their complement
  logic [6:0] seg_on [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic [5:0] lamp_tab [9] = '{6'b100_001, 6'b100_010, 6'b001_100, 6'b010_100,
                               6'b100_100, 6'b001_001, 6'b000_001, 6'b110_001,
                               6'b000_000};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t tick=%0d: got=%0h expected=%0h", tag, $time, n, got, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    disp_ns = 0; disp_ew = 0; disp_l = 6'b0;
    pend_ns = 0; pend_ew = 0; pend_l = 6'b0;
  endtask

  task automatic model_tick();
    n++;
    if (n >= 10 && (n - 10) % 9 == 0) begin
      disp_ns = pend_ns;
      disp_ew = pend_ew;
      disp_l  = pend_l;
    end
    if (n >= 2 && (n - 2) % 9 == 0) begin
      pend_ns = (int'(tl_ns) > 99) ? 99 : int'(tl_ns);
      pend_ew = (int'(tl_ew) > 99) ? 99 : int'(tl_ew);
      pend_l  = lights;
    end
  endtask

  task automatic model_outputs(output logic [6:0] es, output logic [3:0] ea, output logic ed);
    int   dig, val;
    logic yel, blank, legal;
    es = 7'h7F; ea = 4'hF; ed = 1'b1;
    if (n == 0) return;
    dig = (n / SCAN) % 4;
    ea  = ~(4'b0001 << dig);
    legal = ($countones(disp_l[5:3]) == 1) && ($countones(disp_l[2:0]) == 1) &&
            !(disp_l[3] && disp_l[0]);
    if (!legal) begin
      es = 7'h3F;
      return;
    end
    val   = (dig >= 2) ? disp_ns : disp_ew;
    yel   = (dig >= 2) ? disp_l[4] : disp_l[1];
    blank = 1'b0;
`ifdef TRAFFIC_DISPLAY_BLINK_EN
    blank = yel && ((n / BLINK) % 2 == 1);
`endif
    if (dig % 2 == 0) begin
      es = ~seg_on[val % 10];
      ed = ~yel;
    end else begin
      es = (val / 10 == 0) ? 7'h7F : ~seg_on[val / 10];
    end
    if (blank) begin
      es = 7'h7F;
      ed = 1'b1;
    end
  endtask

  task automatic compare_outputs();
    logic [6:0] es;
    logic [3:0] ea;
    logic       ed;
    model_outputs(es, ea, ed);
    check_eq("seg", 32'(seg), 32'(es));
    check_eq("an",  32'(an),  32'(ea));
    check_eq("dp",  32'(dp),  32'(ed));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rst && ce) model_tick();
    compare_outputs();
  endtask

  // ce_mode: 0 = held low, 1 = held high, 2 = random
  task automatic run(input int cycles, input int ce_mode);
    for (int i = 0; i < cycles; i++) begin
      ce = (ce_mode == 2) ? ($urandom_range(3) != 0) : (ce_mode == 1);
      step();
    end
  endtask

  task automatic set_in(input int ns, input int ew, input logic [5:0] l);
    tl_ns  = 7'(ns);
    tl_ew  = 7'(ew);
    lights = l;
  endtask

  initial begin
    model_reset();
    #2 rst = 1'b0;
    #10;
    compare_outputs();
    @(negedge clk) rst = 1'b1;
    run(3, 0);

    set_in(37, 5, 6'b100_001);
    run(40, 1);
    set_in(120, 64, 6'b100_001);
    run(24, 1);
    set_in(0, 99, 6'b001_100);
    run(24, 1);
    set_in(10, 90, 6'b001_001);
    run(12, 1);
    set_in(58, 21, 6'b100_010);
    run(24, 1);
    set_in(42, 17, 6'b010_100);
    run(40, 1);
    run(20, 0);
    run(30, 1);

    // Asynchronous reset in the middle of a conversion
    for (int i = 0; i < 20 && !(n >= 2 && (n - 2) % 9 == 3); i++) run(1, 1);
    check_eq("reset_in_shift", 32'((n - 2) % 9), 32'd3);
    #2 rst = 1'b0;
    #1;
    model_reset();
    compare_outputs();
    @(negedge clk) rst = 1'b1;
    set_in(86, 3, 6'b100_010);
    run(30, 1);

    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(2) == 0)
        set_in($urandom_range(127), $urandom_range(127), lamp_tab[$urandom_range(8)]);
      run(10, 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
